// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream-format constants for the loader.
// IMEM_LOADER_CKSUM_EN adds the CHK state and the checksum seed.
`default_nettype none

package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic [7:0] CKSUM_INIT = 8'h00;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CHK  = 3'd4,
`endif
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word.sv
// word_assembler: places stream bytes little-endian into a 32-bit word and
// flags the byte that completes it.
`default_nettype none

module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  localparam int KW = $clog2(BYTES_PER_WORD);

  logic [KW-1:0] k_q, k_d;
  logic [31:0]   word_q, word_d;

  // word is the current word with the incoming byte already merged, so the
  // top can capture the full word on the completing handshake.
  always_comb begin
    word                    = word_q;
    word[{k_q, 3'b000} +: 8] = byte_in;
    word_complete           = byte_en && (k_q == KW'(BYTES_PER_WORD - 1));
    k_d                     = k_q;
    word_d                  = word_q;
    if (clear) begin
      k_d    = '0;
      word_d = '0;
    end else if (byte_en) begin
      k_d    = k_q + 1'b1;
      word_d = word;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      k_q    <= '0;
      word_q <= '0;
    end else begin
      k_q    <= k_d;
      word_q <= word_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer fed by a byte stream; holds the
// core in reset until loaded. IMEM_LOADER_CKSUM_EN adds a trailing XOR checksum byte.
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IW    = ADDR_W + 1;
  localparam int CW    = 8 * HDR_BYTES;

  state_e               state_q, state_d, after_data;
  logic [CW-1:0]        cnt_q, cnt_d, hdr_cnt;
  logic [IW-1:0]        widx_q, widx_d, widx_inc;
  logic                 we_q, we_d;
  logic [31:0]          waddr_q, waddr_d, wdata_q, wdata_d;
  logic                 fire, asm_clear, asm_en, word_complete;
  logic [31:0]          asm_word;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]           cksum_q, cksum_d;
  assign after_data = S_CHK;
`else
  assign after_data = S_DONE;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
      S_CHK:                  in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  assign busy     = in_ready;
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_rst  = !done;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

  assign fire     = in_valid && in_ready;
  assign asm_en   = fire && (state_q == S_DATA);
  assign hdr_cnt  = {in_data, cnt_q[7:0]};
  assign widx_inc = widx_q + 1'b1;

  word_assembler u_asm (
    .CLK           (CLK),
    .RST           (RST),
    .clear         (asm_clear),
    .byte_en       (asm_en),
    .byte_in       (in_data),
    .word          (asm_word),
    .word_complete (word_complete)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    cksum_d   = cksum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_HDR0;
          widx_d    = '0;
          asm_clear = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
          cksum_d   = CKSUM_INIT;
`endif
        end
      end
      S_HDR0: begin
        if (fire) begin
          cnt_d[7:0] = in_data;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (fire) begin
          cnt_d = hdr_cnt;
          if ({1'b0, hdr_cnt} > (CW + 1)'(DEPTH)) state_d = S_ERR;
          else if (hdr_cnt == '0)                state_d = after_data;
          else                                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fire) begin
`ifdef IMEM_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ in_data;
`endif
          if (word_complete) begin
            we_d    = 1'b1;
            waddr_d = 32'({widx_q, 2'b00});
            wdata_d = asm_word;
            widx_d  = widx_inc;
            // Leave on the same edge that registers the last write.
            if (32'(widx_inc) == 32'(cnt_q)) state_d = after_data;
          end
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CHK: begin
        if (fire) state_d = (in_data == cksum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the core fetches from.
- Accepts a byte stream over a valid/ready handshake, with a 16-bit word-count header followed by little-endian instruction words.
- Writes each assembled 32-bit word to instruction memory at consecutive word-aligned byte addresses.
- Holds the core in reset until the load completes.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous active-high reset.
- start  input  1  begin a load; sampled only in IDLE, DONE and ERR.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer happens when in_valid && in_ready.
- we  output  1  instruction-memory write strobe, one-cycle pulse.
- waddr  output  32  write byte address (word_index*4, bits [1:0] = 0); same addressing as the fetch address.
- wdata  output  32  write data.
- cpu_rst  output  1  core reset request; low only in DONE.
- busy  output  1  high in HDR0, HDR1, DATA and CHK.
- done  output  1  high in DONE.
- err  output  1  high in ERR.

Behaviour:
- States: IDLE, HDR0, HDR1, DATA, CHK (only with the optional feature), DONE, ERR.
- Reset values: state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, cpu_rst=1, busy=0, done=0, err=0. All internal counters and the shift register clear.
- in_ready=1 exactly in HDR0, HDR1, DATA and CHK. It is a combinational function of state; there is no stall, and throughput is one byte per cycle.
- IDLE/DONE/ERR with start=1: next state HDR0, word index cleared, byte counter cleared. cpu_rst returns to 1 on the same edge. start is ignored in all other states.
- HDR0: accepted byte becomes cnt[7:0].
- HDR1: accepted byte becomes cnt[15:8], then:
  - cnt > DEPTH: go to ERR.
  - cnt == 0: go to DONE, or to CHK if the feature is enabled.
  - otherwise: go to DATA.
- DATA, byte assembly:
  - A 2-bit byte counter k places the accepted byte at word[8k+7:8k] (little-endian).
  - On the 4th byte (k=3), the next edge registers we=1, waddr={word_index,2'b00} zero-extended to 32 bits, and wdata=the full word, and increments word_index.
  - we pulses one cycle after the 4th handshake. Back-to-back words therefore produce writes at most every 4 cycles.
- DATA exit: after the write of word cnt-1 is issued, go to DONE, or to CHK if enabled. The state changes on the same edge as that final we is registered.
- Cycles with in_valid=0 freeze all counters; gaps are allowed anywhere.
- DONE: cpu_rst=0, done=1. Bytes presented here are not accepted (in_ready=0).
- ERR: sticky, err=1, cpu_rst=1, no writes. Exit only through start or RST.
- waddr/wdata hold their last values when we=0.
- RST asserted mid-load: all outputs immediately return to reset values and the partial word is discarded. Memory contents already written are not restored.
- Word-index width is ADDR_W+1 so that cnt == DEPTH is legal and does not wrap.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- With the macro defined:
  - An 8-bit running XOR of all DATA bytes is kept; it clears on start.
  - After the last word, state CHK accepts one byte.
  - If that byte equals the XOR, go to DONE; otherwise go to ERR.
  - The words already written remain in memory.
  - For cnt == 0 the expected checksum is 0x00.
- Without the macro: the CHK state, the XOR register and their logic are absent, and the header/data path goes directly to DONE.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum.
  - HDR_BYTES=2.
  - BYTES_PER_WORD=4.
  - CKSUM_INIT=8'h00.
- One natural sub-module, word_assembler: byte counter, 32-bit little-endian shift/placement register, and word_complete pulse. The top module owns the FSM, the counters and the memory-write register.

Test Plan:
- Reset: assert RST mid-cycle without a clock → cpu_rst=1, we=0, in_ready=0, busy=0, done=0, err=0 immediately.
- Two-word load (ADDR_W=8), start, then bytes 02 00 78 56 34 12 EF BE AD DE with in_valid held high → we at waddr=0x0 with wdata=0x12345678, then we at waddr=0x4 with wdata=0xDEADBEEF; then done=1 and cpu_rst=0; exactly two we pulses.
- Zero count: start, 00 00 → done=1 on the next edge, no we. With the feature: one extra byte 00 → done, byte 01 → err.
- Oversize: header 01 01 (257 > 256) → err=1, no we, cpu_rst=1. Then start followed by 01 00 44 33 22 11 → one write of 0x11223344 at addr 0, done=1.
- Stall tolerance: repeat the two-word load with random in_valid gaps of 0–5 cycles → identical write sequence and final state.
- Reset mid-load: assert RST after 6 accepted bytes → reset values. A fresh start and full load then writes the first word to addr 0 with no residue from the partial word.
